// File: rtl/sevenseg_pkg.sv
// Shared definitions for the eight-digit seven-segment display path:
// digit/nibble/word widths, their typedefs, and the nibble helpers used by
// the scan controller, the decoder and the benches.
package sevenseg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEL_W      = 3;
    localparam int NIBBLE_W   = 4;
    localparam int WORD_W     = 32;

    typedef logic [SEL_W-1:0]    sel_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;
    typedef logic [WORD_W-1:0]   word_t;

    // Nibble k of a display word, i.e. bits 4k+3:4k.
    function automatic nibble_t get_nibble(input word_t w, input sel_t k);
        return w[{k, 2'b00} +: NIBBLE_W];
    endfunction

    // True when digit k is a leading zero: k is not digit 0 and nibbles
    // k..7 are all zero. Digit 0 is never reported, so a zero word still
    // shows a single "0".
    function automatic logic is_leading_zero(input word_t w, input sel_t k);
        logic any_nz;
        any_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(k)) && (w[i*NIBBLE_W +: NIBBLE_W] != 4'h0)) begin
                any_nz = 1'b1;
            end
        end
        return (k != sel_t'(0)) && !any_nz;
    endfunction

endpackage

// File: rtl/sevenseg_refresh_timer.sv
// Digit-slot timer: counts 0..REFRESH_DIV-1 and flags the last cycle of each
// slot (slot_tick). in_guard reports whether the count being loaded on the
// next edge falls inside the anti-ghosting blank window at the slot start.
module sevenseg_refresh_timer #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_tick,
    output logic in_guard
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    assign slot_tick = (cnt_r == LAST_CNT);

    // Next count: wrap to zero at the end of a slot, else increment.
    always_comb begin
        cnt_next_s = cnt_r;
        if (slot_tick) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    assign in_guard = (cnt_next_s < GUARD_CNT);

    // Slot counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexing scan controller for the 8-digit seven-segment decoder.
// Steps sel through 0..7 once per REFRESH_DIV cycles, blanks the first GUARD
// cycles of each slot, and double-buffers host writes so that a new display
// word only takes effect on the 7->0 wrap (a frame never mixes two words).
// Optional build macro: SEVENSEG_LZ_SUPPRESS_EN enables leading-zero
// suppression; when undefined every enabled digit is shown.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  digit_en,
    output logic [3:0]  num,
    output logic [2:0]  sel,
    output logic        blank,
    output logic        frame_done,
    output logic        load_ack
);

    logic    slot_tick_s;
    logic    in_guard_s;

    sel_t    sel_r;
    word_t   active_r;
    word_t   pending_r;
    logic    pend_v_r;
    nibble_t num_r;
    logic    blank_r;
    logic    frame_done_r;
    logic    load_ack_r;

    sel_t    sel_next_s;
    logic    wrap_s;
    word_t   active_next_s;
    word_t   pending_next_s;
    logic    pend_v_next_s;
    logic    load_ack_next_s;
    logic    lz_blank_s;
    logic    blank_next_s;
    nibble_t num_next_s;

    sevenseg_refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD       (GUARD)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_tick (slot_tick_s),
        .in_guard  (in_guard_s)
    );

    // Digit select advance and frame-wrap detection.
    always_comb begin
        sel_next_s = sel_r;
        wrap_s     = 1'b0;
        if (slot_tick_s) begin
            sel_next_s = sel_t'(sel_r + 3'd1);
            wrap_s     = (sel_r == sel_t'(NUM_DIGITS - 1));
        end else begin
            sel_next_s = sel_r;
            wrap_s     = 1'b0;
        end
    end

    // Write buffering and frame commit. A load on the wrap edge bypasses the
    // pending buffer and lands in the active word directly.
    always_comb begin
        active_next_s   = active_r;
        pending_next_s  = pending_r;
        pend_v_next_s   = pend_v_r;
        load_ack_next_s = 1'b0;
        if (load) begin
            pending_next_s = data_in;
        end else begin
            pending_next_s = pending_r;
        end
        if (wrap_s) begin
            pend_v_next_s = 1'b0;
            if (load) begin
                active_next_s   = data_in;
                load_ack_next_s = 1'b1;
            end else if (pend_v_r) begin
                active_next_s   = pending_r;
                load_ack_next_s = 1'b1;
            end else begin
                active_next_s   = active_r;
                load_ack_next_s = 1'b0;
            end
        end else if (load) begin
            pend_v_next_s = 1'b1;
        end else begin
            pend_v_next_s = pend_v_r;
        end
    end

    // Leading-zero suppression works on the post-commit word so it lines up
    // with the digit being displayed after the same edge.
    always_comb begin
        lz_blank_s = 1'b0;
`ifdef SEVENSEG_LZ_SUPPRESS_EN
        lz_blank_s = is_leading_zero(active_next_s, sel_next_s);
`else
        lz_blank_s = 1'b0;
`endif
    end

    // Next values of the decoder-facing outputs.
    always_comb begin
        num_next_s   = get_nibble(active_next_s, sel_next_s);
        blank_next_s = in_guard_s | ~digit_en[sel_next_s] | lz_blank_s;
    end

    // Digit select and display buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r     <= sel_t'(0);
            active_r  <= word_t'(0);
            pending_r <= word_t'(0);
            pend_v_r  <= 1'b0;
        end else begin
            sel_r     <= sel_next_s;
            active_r  <= active_next_s;
            pending_r <= pending_next_s;
            pend_v_r  <= pend_v_next_s;
        end
    end

    // Registered outputs, all updated on the same edge as sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_r        <= nibble_t'(0);
            blank_r      <= 1'b1;
            frame_done_r <= 1'b0;
            load_ack_r   <= 1'b0;
        end else begin
            num_r        <= num_next_s;
            blank_r      <= blank_next_s;
            frame_done_r <= wrap_s;
            load_ack_r   <= load_ack_next_s;
        end
    end

    assign num        = num_r;
    assign sel        = sel_r;
    assign blank      = blank_r;
    assign frame_done = frame_done_r;
    assign load_ack   = load_ack_r;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl (REFRESH_DIV=8, GUARD=2).
// The reference model counts edges since reset and derives slot position,
// digit index and frame boundaries arithmetically; host writes are tracked
// as a pending value that is committed on every 64th edge.
module tb_sevenseg_scan_ctrl;

    localparam int RDIV  = 8;
    localparam int GRD   = 2;
    localparam int FRAME = RDIV * 8;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  digit_en;
    logic [3:0]  num;
    logic [2:0]  sel;
    logic        blank;
    logic        frame_done;
    logic        load_ack;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_cyc;
    logic [31:0] m_active;
    logic [31:0] m_pending;
    logic        m_pend_v;
    logic [7:0]  m_en;
    logic        m_fd;
    logic        m_ack;

    logic [7:0]  cur_en;

    sevenseg_scan_ctrl #(
        .REFRESH_DIV (RDIV),
        .GUARD       (GRD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data_in    (data_in),
        .digit_en   (digit_en),
        .num        (num),
        .sel        (sel),
        .blank      (blank),
        .frame_done (frame_done),
        .load_ack   (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        m_cyc     = 0;
        m_active  = 32'h0;
        m_pending = 32'h0;
        m_pend_v  = 1'b0;
        m_fd      = 1'b0;
        m_ack     = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_sel"},   32'(sel),        32'd0);
        chk({tag, "_num"},   32'(num),        32'd0);
        chk({tag, "_blank"}, 32'(blank),      32'd1);
        chk({tag, "_fd"},    32'(frame_done), 32'd0);
        chk({tag, "_ack"},   32'(load_ack),   32'd0);
    endtask

    // Advance the model by one edge with the inputs seen on that edge.
    task automatic model_edge(input logic ld, input logic [31:0] d, input logic [7:0] en);
        m_cyc = m_cyc + 1;
        m_en  = en;
        m_fd  = ((m_cyc % FRAME) == 0);
        m_ack = 1'b0;
        if (m_fd) begin
            if (ld) begin
                m_active = d;
                m_ack    = 1'b1;
            end else if (m_pend_v) begin
                m_active = m_pending;
                m_ack    = 1'b1;
            end
            m_pend_v = 1'b0;
        end else if (ld) begin
            m_pending = d;
            m_pend_v  = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        int          slot_pos;
        int          digit;
        logic [31:0] upper;
        logic        exp_blank;
        slot_pos  = m_cyc % RDIV;
        digit     = (m_cyc / RDIV) % 8;
        upper     = m_active >> (4 * digit);
        exp_blank = (slot_pos < GRD) || !m_en[digit];
`ifdef SEVENSEG_LZ_SUPPRESS_EN
        if ((digit != 0) && (upper == 32'h0)) exp_blank = 1'b1;
`endif
        chk({tag, "_sel"},   32'(sel),        32'(digit));
        chk({tag, "_num"},   32'(num),        upper & 32'hF);
        chk({tag, "_blank"}, 32'(blank),      32'(exp_blank));
        chk({tag, "_fd"},    32'(frame_done), 32'(m_fd));
        chk({tag, "_ack"},   32'(load_ack),   32'(m_ack));
    endtask

    // One clock: drive inputs, take the edge, check #1 later.
    task automatic step(input string tag, input logic ld, input logic [31:0] d);
        load     = ld;
        data_in  = d;
        digit_en = cur_en;
        @(posedge clk);
        #1;
        model_edge(ld, d, cur_en);
        check_model(tag);
        load = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 32'h0);
    endtask

    // Idle until the next edge is the frame-wrap edge.
    task automatic to_wrap_edge(input string tag);
        for (int i = 0; i < FRAME && ((m_cyc % FRAME) != FRAME - 1); i++) begin
            step(tag, 1'b0, 32'h0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        data_in  = 32'h0;
        cur_en   = 8'hFF;
        digit_en = cur_en;
        m_en     = cur_en;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: free-running scan with no writes, slightly more than two frames
        idle("scan", 2 * FRAME + 5);

        // 2: mid-frame write, visible only after the wrap
        step("ld1", 1'b1, 32'h89ABCDEF);
        to_wrap_edge("ld1_wait");
        idle("ld1_frame", FRAME);

        // 3: two writes in one frame, the latest wins, single ack
        idle("ld2_pre", 10);
        step("ld2a", 1'b1, 32'h11111111);
        idle("ld2_mid", 7);
        step("ld2b", 1'b1, 32'h22222222);
        to_wrap_edge("ld2_wait");
        idle("ld2_frame", FRAME + 2);

        // 4: write exactly on the wrap edge commits immediately
        to_wrap_edge("ldw_wait");
        step("ldw", 1'b1, 32'h12345678);
        chk("ldw_digit0", 32'(num), 32'h8);
        idle("ldw_frame", FRAME + 2);

        // 5: alternate digits disabled
        cur_en = 8'b1010_1010;
        idle("mask", FRAME + 3);
        cur_en = 8'hFF;
        step("unmask", 1'b0, 32'h0);

        // 6: small value and zero (leading-zero behaviour depends on build)
        step("lza", 1'b1, 32'h000000A5);
        to_wrap_edge("lza_wait");
        idle("lza_frame", FRAME);
        step("lz0", 1'b1, 32'h00000000);
        to_wrap_edge("lz0_wait");
        idle("lz0_frame", FRAME);

        // Randomised traffic: sparse writes and occasional mask changes
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(31, 0) == 0) cur_en = 8'($urandom());
            if ($urandom_range(15, 0) == 0) step("rnd", 1'b1, $urandom());
            else                             step("rnd", 1'b0, 32'h0);
        end

        // Mid-frame reset with a pending write outstanding
        cur_en = 8'hFF;
        step("prerst", 1'b1, 32'hDEADBEEF);
        idle("prerst", 13);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle("postrst", FRAME + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
